// File: rtl/rtc_sync_ctrl_if.sv
// Bus bundle for rtc_sync_ctrl: sample input from the gPTP timestamp engine
// and the update request/response towards the RTC.
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both 1; while valid is 1 and ready is 0 the
// producer keeps valid and every data field stable, and the consumer may
// raise ready at any time without looking at valid first.
interface rtc_sync_ctrl_if;
    // sample channel (timestamp engine -> controller)
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] t1_epoch;
    logic [31:0] t1_sec;
    logic [31:0] t1_nano;
    logic [15:0] t2_epoch;
    logic [31:0] t2_sec;
    logic [31:0] t2_nano;
    logic [31:0] path_delay_ns;
    // update channel (controller -> RTC)
    logic        gptp_vaild;
    logic        gptp_sw;
    logic        rtc_ready;
    logic [15:0] syntonised_epoch_field_r;
    logic [31:0] syntonised_sec_field_r;
    logic [31:0] syntonised_nanosec_field_r;
    logic [15:0] epoch_offset;
    logic [31:0] sec_offset;
    logic [29:0] nanosec_offset;
    // status
    logic        err_invalid;
    logic [15:0] step_count;
    logic [15:0] update_count;

    // Environment side: supplies samples and plays the RTC.
    modport master (
        output sample_valid, t1_epoch, t1_sec, t1_nano,
               t2_epoch, t2_sec, t2_nano, path_delay_ns, rtc_ready,
        input  sample_ready, gptp_vaild, gptp_sw,
               syntonised_epoch_field_r, syntonised_sec_field_r,
               syntonised_nanosec_field_r, epoch_offset, sec_offset,
               nanosec_offset, err_invalid, step_count, update_count
    );

    // Controller side.
    modport slave (
        input  sample_valid, t1_epoch, t1_sec, t1_nano,
               t2_epoch, t2_sec, t2_nano, path_delay_ns, rtc_ready,
        output sample_ready, gptp_vaild, gptp_sw,
               syntonised_epoch_field_r, syntonised_sec_field_r,
               syntonised_nanosec_field_r, epoch_offset, sec_offset,
               nanosec_offset, err_invalid, step_count, update_count
    );
endinterface

// File: rtl/rtc_sync_ctrl.sv
// gPTP correction initiator. Takes one (t1, path delay, t2) sample, computes
// offset = (t1 + path_delay) - t2 over three cycles, then either steps the RTC
// to the target time (followed by a zero offset write) or writes the offset.
// Seconds are handled as one 48-bit {epoch, sec} quantity; nanoseconds are
// always kept normalised to [0, 1e9).
module rtc_sync_ctrl #(
    parameter logic [31:0] C_STEP_COMP_NS = 32'd4,
    parameter bit          C_STEP_ENABLE  = 1'b1
) (
    input  logic           rtc_clk,
    input  logic           rtc_reset,
    rtc_sync_ctrl_if.slave bus,
    output logic [2:0]     dbg_state
);

    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SUB      = 3'd2,
        S_DECIDE   = 3'd3,
        S_STEP_REQ = 3'd4,
        S_OFFS_REQ = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [47:0] t1_s_q, t1_s_d;
    logic [31:0] t1_ns_q, t1_ns_d;
    logic [31:0] pd_q, pd_d;
    logic [47:0] t2_s_q, t2_s_d;
    logic [31:0] t2_ns_q, t2_ns_d;
    logic [47:0] tgt_s_q, tgt_s_d;
    logic [31:0] tgt_ns_q, tgt_ns_d;
    logic [47:0] off_s_q, off_s_d;
    logic [29:0] off_ns_q, off_ns_d;
    logic [15:0] epoch_off_q, epoch_off_d;
    logic [31:0] sec_off_q, sec_off_d;
    logic [29:0] nsec_off_q, nsec_off_d;
    logic [15:0] syn_ep_q, syn_ep_d;
    logic [31:0] syn_sec_q, syn_sec_d;
    logic [31:0] syn_ns_q, syn_ns_d;
    logic        vaild_q, vaild_d;
    logic        sw_q, sw_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic [15:0] upd_cnt_q, upd_cnt_d;

    logic [31:0] ns_sum;
    logic [31:0] ld_sum;
    logic        bad_sample;
    logic        take_step;
    logic        xfer;

    // Next-state and datapath: one arithmetic stage per state, outputs registered.
    always_comb begin
        state_d     = state_q;
        t1_s_d      = t1_s_q;
        t1_ns_d     = t1_ns_q;
        pd_d        = pd_q;
        t2_s_d      = t2_s_q;
        t2_ns_d     = t2_ns_q;
        tgt_s_d     = tgt_s_q;
        tgt_ns_d    = tgt_ns_q;
        off_s_d     = off_s_q;
        off_ns_d    = off_ns_q;
        epoch_off_d = epoch_off_q;
        sec_off_d   = sec_off_q;
        nsec_off_d  = nsec_off_q;
        syn_ep_d    = syn_ep_q;
        syn_sec_d   = syn_sec_q;
        syn_ns_d    = syn_ns_q;
        vaild_d     = vaild_q;
        sw_d        = sw_q;
        ready_d     = ready_q;
        err_d       = 1'b0;
        step_cnt_d  = step_cnt_q;
        upd_cnt_d   = upd_cnt_q;

        ns_sum     = t1_ns_q + pd_q;
        ld_sum     = tgt_ns_q + C_STEP_COMP_NS;
        bad_sample = (bus.t1_nano >= NS_PER_SEC) || (bus.t2_nano >= NS_PER_SEC) ||
                     (bus.path_delay_ns >= NS_PER_SEC);
        take_step  = C_STEP_ENABLE && (off_s_q != 48'h0) && (off_s_q != 48'hFFFF_FFFF_FFFF);
        xfer       = vaild_q && bus.rtc_ready;

        case (state_q)
            S_IDLE: begin
                if (bus.sample_valid && ready_q) begin
                    if (bad_sample) begin
                        // Out-of-range nanoseconds: drop the sample, keep nothing.
                        err_d = 1'b1;
                    end else begin
                        t1_s_d  = {bus.t1_epoch, bus.t1_sec};
                        t1_ns_d = bus.t1_nano;
                        pd_d    = bus.path_delay_ns;
                        t2_s_d  = {bus.t2_epoch, bus.t2_sec};
                        t2_ns_d = bus.t2_nano;
                        ready_d = 1'b0;
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                // Both addends are below 1e9, so at most one carry into seconds.
                if (ns_sum >= NS_PER_SEC) begin
                    tgt_ns_d = ns_sum - NS_PER_SEC;
                    tgt_s_d  = t1_s_q + 48'd1;
                end else begin
                    tgt_ns_d = ns_sum;
                    tgt_s_d  = t1_s_q;
                end
                state_d = S_SUB;
            end
            S_SUB: begin
                // Borrow keeps off_ns non-negative; off_s becomes two's complement.
                if (tgt_ns_q < t2_ns_q) begin
                    off_ns_d = 30'(tgt_ns_q + NS_PER_SEC - t2_ns_q);
                    off_s_d  = tgt_s_q - t2_s_q - 48'd1;
                end else begin
                    off_ns_d = 30'(tgt_ns_q - t2_ns_q);
                    off_s_d  = tgt_s_q - t2_s_q;
                end
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                vaild_d = 1'b1;
                if (take_step) begin
                    // Load value leads the target by the RTC load latency.
                    if (ld_sum >= NS_PER_SEC) begin
                        syn_ns_d             = ld_sum - NS_PER_SEC;
                        {syn_ep_d, syn_sec_d} = tgt_s_q + 48'd1;
                    end else begin
                        syn_ns_d             = ld_sum;
                        {syn_ep_d, syn_sec_d} = tgt_s_q;
                    end
                    sw_d    = 1'b0;
                    state_d = S_STEP_REQ;
                end else begin
                    epoch_off_d = off_s_q[47:32];
                    sec_off_d   = off_s_q[31:0];
                    nsec_off_d  = off_ns_q;
                    sw_d        = 1'b1;
                    state_d     = S_OFFS_REQ;
                end
            end
            S_STEP_REQ: begin
                if (xfer) begin
                    // After a step, clear the offset so synchronised time equals stepped time.
                    step_cnt_d  = step_cnt_q + 16'd1;
                    epoch_off_d = 16'h0;
                    sec_off_d   = 32'h0;
                    nsec_off_d  = 30'h0;
                    sw_d        = 1'b1;
                    state_d     = S_OFFS_REQ;
                end
            end
            S_OFFS_REQ: begin
                if (xfer) begin
                    upd_cnt_d = upd_cnt_q + 16'd1;
                    vaild_d   = 1'b0;
                    ready_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                vaild_d = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending request immediately.
    always_ff @(posedge rtc_clk) begin
        if (rtc_reset) begin
            state_q     <= S_IDLE;
            t1_s_q      <= '0;
            t1_ns_q     <= '0;
            pd_q        <= '0;
            t2_s_q      <= '0;
            t2_ns_q     <= '0;
            tgt_s_q     <= '0;
            tgt_ns_q    <= '0;
            off_s_q     <= '0;
            off_ns_q    <= '0;
            epoch_off_q <= '0;
            sec_off_q   <= '0;
            nsec_off_q  <= '0;
            syn_ep_q    <= '0;
            syn_sec_q   <= '0;
            syn_ns_q    <= '0;
            vaild_q     <= 1'b0;
            sw_q        <= 1'b0;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
            step_cnt_q  <= '0;
            upd_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            t1_s_q      <= t1_s_d;
            t1_ns_q     <= t1_ns_d;
            pd_q        <= pd_d;
            t2_s_q      <= t2_s_d;
            t2_ns_q     <= t2_ns_d;
            tgt_s_q     <= tgt_s_d;
            tgt_ns_q    <= tgt_ns_d;
            off_s_q     <= off_s_d;
            off_ns_q    <= off_ns_d;
            epoch_off_q <= epoch_off_d;
            sec_off_q   <= sec_off_d;
            nsec_off_q  <= nsec_off_d;
            syn_ep_q    <= syn_ep_d;
            syn_sec_q   <= syn_sec_d;
            syn_ns_q    <= syn_ns_d;
            vaild_q     <= vaild_d;
            sw_q        <= sw_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            step_cnt_q  <= step_cnt_d;
            upd_cnt_q   <= upd_cnt_d;
        end
    end

    assign bus.sample_ready               = ready_q;
    assign bus.gptp_vaild                 = vaild_q;
    assign bus.gptp_sw                    = sw_q;
    assign bus.syntonised_epoch_field_r   = syn_ep_q;
    assign bus.syntonised_sec_field_r     = syn_sec_q;
    assign bus.syntonised_nanosec_field_r = syn_ns_q;
    assign bus.epoch_offset               = epoch_off_q;
    assign bus.sec_offset                 = sec_off_q;
    assign bus.nanosec_offset             = nsec_off_q;
    assign bus.err_invalid                = err_q;
    assign bus.step_count                 = step_cnt_q;
    assign bus.update_count               = upd_cnt_q;
    assign dbg_state                      = state_q;

endmodule

// File: tb/tb_rtc_sync_ctrl.sv
// Bench for rtc_sync_ctrl: table of samples with hand-derived expected RTC
// requests, a scoreboard queue checked at every transfer, and short sequences
// for backpressure, reset mid-handshake and the step-disabled variant.
module tb_rtc_sync_ctrl;

    localparam int W = 81;  // {sw, epoch, sec, nsec}

    logic       rtc_clk = 1'b0;
    logic       rtc_reset = 1'b1;
    logic [2:0] dbg_state;
    logic [2:0] dbg_state_ns;

    rtc_sync_ctrl_if bus ();
    rtc_sync_ctrl_if bus_ns ();

    rtc_sync_ctrl u_dut (
        .rtc_clk  (rtc_clk),
        .rtc_reset(rtc_reset),
        .bus      (bus.slave),
        .dbg_state(dbg_state)
    );

    rtc_sync_ctrl #(.C_STEP_COMP_NS(32'd4), .C_STEP_ENABLE(1'b0)) u_dut_nostep (
        .rtc_clk  (rtc_clk),
        .rtc_reset(rtc_reset),
        .bus      (bus_ns.slave),
        .dbg_state(dbg_state_ns)
    );

    // clock/reset block
    always #5 rtc_clk = ~rtc_clk;

    typedef struct {
        bit          err;
        logic [15:0] t1e;
        logic [31:0] t1s;
        logic [31:0] t1n;
        logic [31:0] pd;
        logic [15:0] t2e;
        logic [31:0] t2s;
        logic [31:0] t2n;
        bit          step;
        logic [15:0] ee;
        logic [31:0] es;
        logic [31:0] en;
    } vec_t;

    vec_t         vecs[13];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           exp_steps = 0;
    int           exp_upd = 0;
    bit           rand_ready = 1'b0;
    logic [W-1:0] held;
    bit           held_v = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] mk_req(input bit sw, input logic [15:0] e,
                                            input logic [31:0] s, input logic [31:0] n);
        return {sw, e, s, n};
    endfunction

    task automatic tick();
        @(posedge rtc_clk);
        #1;
    endtask

    // RTC ready driver: random acceptance when enabled
    always @(posedge rtc_clk) begin
        #1;
        if (rand_ready) bus.rtc_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard monitor: compares each transfer and checks hold-while-stalled
    always @(negedge rtc_clk) begin
        logic [W-1:0] cur;
        if (rtc_reset) begin
            held_v = 1'b0;
        end else begin
            if (bus.gptp_sw)
                cur = mk_req(1'b1, bus.epoch_offset, bus.sec_offset, {2'b00, bus.nanosec_offset});
            else
                cur = mk_req(1'b0, bus.syntonised_epoch_field_r, bus.syntonised_sec_field_r,
                             bus.syntonised_nanosec_field_r);
            if (held_v) begin
                check("hold_vaild", W'(bus.gptp_vaild), W'(1));
                if (bus.gptp_vaild) check("hold_data", cur, held);
            end
            held_v = 1'b0;
            if (bus.gptp_vaild) begin
                check("ready_low_busy", W'(bus.sample_ready), W'(0));
                if (bus.rtc_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: got %0h expected none", cur);
                    end else begin
                        check("req", cur, exp_q.pop_front());
                    end
                end else begin
                    held   = cur;
                    held_v = 1'b1;
                end
            end
        end
    end

    // driver: apply one sample, check latency, wait for completion
    task automatic run_vec(input vec_t v, input string tag);
        bit done;
        bus.t1_epoch      = v.t1e;
        bus.t1_sec        = v.t1s;
        bus.t1_nano       = v.t1n;
        bus.path_delay_ns = v.pd;
        bus.t2_epoch      = v.t2e;
        bus.t2_sec        = v.t2s;
        bus.t2_nano       = v.t2n;
        bus.sample_valid  = 1'b1;
        if (!v.err) begin
            if (v.step) begin
                exp_q.push_back(mk_req(1'b0, v.ee, v.es, v.en));
                exp_q.push_back(mk_req(1'b1, 16'h0, 32'h0, 32'h0));
                exp_steps++;
            end else begin
                exp_q.push_back(mk_req(1'b1, v.ee, v.es, v.en));
            end
            exp_upd++;
        end
        tick();
        bus.sample_valid = 1'b0;
        check({tag, "_err"}, W'(bus.err_invalid), W'(v.err));
        if (v.err) begin
            for (int c = 0; c < 6; c++) begin
                tick();
                check({tag, "_err_pulse_end"}, W'({bus.err_invalid, bus.gptp_vaild, bus.sample_ready}), W'(3'b001));
            end
        end else begin
            for (int c = 1; c < 4; c++) begin
                check({tag, "_vaild_early"}, W'(bus.gptp_vaild), W'(0));
                tick();
            end
            check({tag, "_vaild_c4"}, W'(bus.gptp_vaild), W'(1));
            check({tag, "_sw_c4"}, W'(bus.gptp_sw), W'(!v.step));
            done = 1'b0;
            for (int k = 0; k < 300; k++) begin
                if (bus.sample_ready && !bus.gptp_vaild && exp_q.size() == 0) begin
                    done = 1'b1;
                    break;
                end
                tick();
            end
            check({tag, "_done_timeout"}, W'(done), W'(1));
        end
        check({tag, "_step_count"}, W'(bus.step_count), W'(exp_steps));
        check({tag, "_update_count"}, W'(bus.update_count), W'(exp_upd));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // err, t1{e,s,n}, pd, t2{e,s,n}, step, expected first request {e,s,n}
        vecs[0]  = '{1'b0, 16'd0, 32'd100, 32'd500000000, 32'd1000, 16'd0, 32'd100, 32'd500000400,
                     1'b0, 16'd0, 32'd0, 32'd600};
        vecs[1]  = '{1'b0, 16'd0, 32'd100, 32'd500000000, 32'd1000, 16'd0, 32'd100, 32'd500001600,
                     1'b0, 16'hFFFF, 32'hFFFFFFFF, 32'd999999400};
        vecs[2]  = '{1'b0, 16'd0, 32'd7, 32'd999999500, 32'd1000, 16'd0, 32'd8, 32'd0,
                     1'b0, 16'd0, 32'd0, 32'd500};
        vecs[3]  = '{1'b0, 16'd0, 32'd200, 32'd0, 32'd0, 16'd0, 32'd100, 32'd0,
                     1'b1, 16'd0, 32'd200, 32'd4};
        vecs[4]  = '{1'b0, 16'd0, 32'd100, 32'd0, 32'd0, 16'd0, 32'd200, 32'd0,
                     1'b1, 16'd0, 32'd100, 32'd4};
        vecs[5]  = '{1'b0, 16'd0, 32'hFFFFFFFF, 32'd999999999, 32'd1, 16'd1, 32'd0, 32'd0,
                     1'b0, 16'd0, 32'd0, 32'd0};
        vecs[6]  = '{1'b0, 16'd3, 32'd50, 32'd999999998, 32'd0, 16'd3, 32'd10, 32'd0,
                     1'b1, 16'd3, 32'd51, 32'd2};
        vecs[7]  = '{1'b0, 16'd0, 32'd5, 32'd0, 32'd0, 16'd0, 32'd5, 32'd999999999,
                     1'b0, 16'hFFFF, 32'hFFFFFFFF, 32'd1};
        vecs[8]  = '{1'b0, 16'd2, 32'd0, 32'd100, 32'd50, 16'd1, 32'hFFFFFFFF, 32'd0,
                     1'b1, 16'd2, 32'd0, 32'd154};
        vecs[9]  = '{1'b0, 16'd0, 32'd9, 32'd999999999, 32'd0, 16'd0, 32'd9, 32'd0,
                     1'b0, 16'd0, 32'd0, 32'd999999999};
        vecs[10] = '{1'b1, 16'd0, 32'd1, 32'd0, 32'd0, 16'd0, 32'd1, 32'h3B9ACA00,
                     1'b0, 16'd0, 32'd0, 32'd0};
        vecs[11] = '{1'b1, 16'd0, 32'd1, 32'h3B9ACA00, 32'd0, 16'd0, 32'd1, 32'd0,
                     1'b0, 16'd0, 32'd0, 32'd0};
        vecs[12] = '{1'b1, 16'd0, 32'd1, 32'd0, 32'h3B9ACA00, 16'd0, 32'd1, 32'd0,
                     1'b0, 16'd0, 32'd0, 32'd0};

        bus.sample_valid = 1'b0;
        bus.t1_epoch = '0; bus.t1_sec = '0; bus.t1_nano = '0; bus.path_delay_ns = '0;
        bus.t2_epoch = '0; bus.t2_sec = '0; bus.t2_nano = '0; bus.rtc_ready = 1'b0;
        bus_ns.sample_valid = 1'b0;
        bus_ns.t1_epoch = '0; bus_ns.t1_sec = '0; bus_ns.t1_nano = '0; bus_ns.path_delay_ns = '0;
        bus_ns.t2_epoch = '0; bus_ns.t2_sec = '0; bus_ns.t2_nano = '0; bus_ns.rtc_ready = 1'b1;

        // reset state
        rtc_reset = 1'b1;
        repeat (3) tick();
        check("rst_sample_ready", W'(bus.sample_ready), W'(1));
        check("rst_vaild_sw_err", W'({bus.gptp_vaild, bus.gptp_sw, bus.err_invalid}), W'(0));
        check("rst_counts", W'({bus.step_count, bus.update_count}), W'(0));
        check("rst_offsets", {1'b0, bus.epoch_offset, bus.sec_offset, 2'b00, bus.nanosec_offset}, W'(0));
        check("rst_syn", {1'b0, bus.syntonised_epoch_field_r, bus.syntonised_sec_field_r,
                          bus.syntonised_nanosec_field_r}, W'(0));
        check("rst_state", W'(dbg_state), W'(0));
        rtc_reset = 1'b0;
        tick();

        // table-driven vectors with random RTC backpressure, back to back
        rand_ready = 1'b1;
        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // idle hold: offsets from vec9, load value from vec8
        check("idle_offset_hold", {1'b0, bus.epoch_offset, bus.sec_offset, 2'b00, bus.nanosec_offset},
              mk_req(1'b0, 16'd0, 32'd0, 32'd999999999));
        check("idle_syn_hold", {1'b0, bus.syntonised_epoch_field_r, bus.syntonised_sec_field_r,
                                bus.syntonised_nanosec_field_r}, mk_req(1'b0, 16'd2, 32'd0, 32'd154));

        // backpressure then reset mid-handshake
        rand_ready = 1'b0;
        bus.rtc_ready = 1'b0;
        tick();
        bus.t1_epoch = 16'd0; bus.t1_sec = 32'd100; bus.t1_nano = 32'd500000000;
        bus.path_delay_ns = 32'd1000;
        bus.t2_epoch = 16'd0; bus.t2_sec = 32'd100; bus.t2_nano = 32'd500000400;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        repeat (3) tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_vaild", W'(bus.gptp_vaild), W'(1));
            check("bp_sample_ready", W'(bus.sample_ready), W'(0));
            check("bp_data", {bus.gptp_sw, bus.epoch_offset, bus.sec_offset, 2'b00, bus.nanosec_offset},
                  mk_req(1'b1, 16'd0, 32'd0, 32'd600));
            tick();
        end
        rtc_reset = 1'b1;
        tick();
        check("rst_mid_vaild", W'(bus.gptp_vaild), W'(0));
        check("rst_mid_sample_ready", W'(bus.sample_ready), W'(1));
        check("rst_mid_counts", W'({bus.step_count, bus.update_count}), W'(0));
        check("rst_mid_offset", W'(bus.nanosec_offset), W'(0));
        exp_q.delete();
        exp_steps = 0;
        exp_upd = 0;
        rtc_reset = 1'b0;
        tick();

        // recovery after reset: step sequence with RTC always ready
        bus.rtc_ready = 1'b1;
        run_vec(vecs[3], "post_rst_step");

        // step disabled: a large offset becomes a single offset write
        bus_ns.t1_epoch = 16'd0; bus_ns.t1_sec = 32'd200; bus_ns.t1_nano = 32'd0;
        bus_ns.path_delay_ns = 32'd0;
        bus_ns.t2_epoch = 16'd0; bus_ns.t2_sec = 32'd100; bus_ns.t2_nano = 32'd0;
        bus_ns.sample_valid = 1'b1;
        tick();
        bus_ns.sample_valid = 1'b0;
        repeat (3) tick();
        check("nostep_vaild_sw", W'({bus_ns.gptp_vaild, bus_ns.gptp_sw}), W'(2'b11));
        check("nostep_offset", {1'b1, bus_ns.epoch_offset, bus_ns.sec_offset, 2'b00, bus_ns.nanosec_offset},
              mk_req(1'b1, 16'd0, 32'd100, 32'd0));
        tick();
        check("nostep_counts", W'({bus_ns.step_count, bus_ns.update_count}), W'({16'd0, 16'd1}));
        check("nostep_idle", W'({bus_ns.gptp_vaild, bus_ns.sample_ready}), W'(2'b01));

        check("final_queue_empty", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_sync_ctrl.md
Name: rtc_sync_ctrl

Overview:
- gPTP correction initiator that drives the update side of the local RTC.
- Takes one time-sync sample per transaction:
  - master origin timestamp t1
  - link path delay
  - local syntonised receive timestamp t2
- Computes offset = (t1 + path_delay) − t2 and issues either a phase-offset write or a full time step into the RTC.
- Sits between the gPTP message/timestamp engine and the RTC.

Parameters:
- C_STEP_COMP_NS, 32'd4: nanoseconds added to the loaded time on a step, compensating the RTC load latency.
- C_STEP_ENABLE, 1: 1 = large offsets cause a step; 0 = always use offset writes.

Ports:
- rtc_clk  in  1  sole clock.
- rtc_reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  sample present.
- sample_ready  out  1  block can accept a sample.
- t1_epoch  in  16  master origin epoch.
- t1_sec  in  32  master origin seconds.
- t1_nano  in  32  master origin nanoseconds.
- t2_epoch  in  16  local rx epoch.
- t2_sec  in  32  local rx seconds.
- t2_nano  in  32  local rx nanoseconds.
- path_delay_ns  in  32  mean link delay; must be < 1e9.
- syntonised_epoch_field_r  out  16  step load value, epoch.
- syntonised_sec_field_r  out  32  step load value, seconds.
- syntonised_nanosec_field_r  out  32  step load value, nanoseconds.
- epoch_offset  out  16  offset, epoch.
- sec_offset  out  32  offset, seconds.
- nanosec_offset  out  30  offset, nanoseconds.
- gptp_vaild  out  1  update request to the RTC.
- gptp_sw  out  1  1 = offset write, 0 = syntonised step.
- rtc_ready  in  1  RTC accepts the request.
- err_invalid  out  1  one-cycle pulse: sample dropped.
- step_count  out  16  number of completed steps.
- update_count  out  16  number of completed offset writes.

Behaviour:
- Reset, synchronous, active-high: every output is 0 except sample_ready = 1, the FSM returns to IDLE, and any pending request is dropped. This holds even mid-handshake: gptp_vaild is 0 the cycle after reset is sampled.
- FSM states: IDLE, ADD, SUB, DECIDE, STEP_REQ, OFFS_REQ.
- IDLE:
  - sample_ready = 1.
  - On sample_valid & sample_ready, register all inputs and go to ADD.
  - If t1_nano, t2_nano or path_delay_ns ≥ 32'h3B9ACA00: pulse err_invalid, stay in IDLE, store nothing.
- ADD (cycle 1):
  - target = t1 + path_delay.
  - Nanosecond sum computed 32-bit; if ≥ 1e9, subtract 1e9 and carry 1 into the 48-bit {epoch,sec}.
- SUB (cycle 2):
  - off = target − t2.
  - Nanosecond field: if target_ns < t2_ns, add 1e9 and borrow 1 from the 48-bit seconds.
  - Seconds wrap modulo 2^48.
  - Result is always normalised: off_ns in [0, 1e9), off_sec a 48-bit two's-complement value. Example: −600 ns is represented as off_sec = 48'hFFFF_FFFF_FFFF, off_ns = 999999400.
- DECIDE (cycle 3):
  - Step condition: C_STEP_ENABLE = 1 and off_sec ∉ {0, 48'hFFFF_FFFF_FFFF}, i.e. |offset| ≥ 1 s, roughly.
  - If stepping, go to STEP_REQ. Load value = target + C_STEP_COMP_NS, normalised with carry as in ADD.
  - Otherwise go to OFFS_REQ with the offset outputs = off.
- Handshake:
  - gptp_vaild rises in cycle 4 after acceptance.
  - gptp_vaild and all data outputs are held stable until the cycle where gptp_vaild & rtc_ready are both 1; the transfer completes on that cycle.
  - gptp_vaild drops the next cycle unless a further request follows.
  - gptp_sw is valid whenever gptp_vaild = 1.
- STEP_REQ:
  - gptp_sw = 0, syntonised_*_r carry the load value.
  - On transfer, step_count increments and the FSM goes to OFFS_REQ with offsets = 0. This clears any previous offset so that synchronized time equals stepped time.
- OFFS_REQ:
  - gptp_sw = 1, offset outputs carry the offset.
  - On transfer, update_count increments and the FSM returns to IDLE.
- Offset outputs hold their last written value while idle. syntonised_*_r hold the last step value.
- Counters wrap from 16'hFFFF to 0.
- sample_ready = 0 in every state except IDLE. No sample is queued.
- Back-to-back operation: a sample may be accepted in the cycle after returning to IDLE.

Test Plan:
- Positive offset: t1 = {0,100,500000000}, delay 1000, t2 = {0,100,500000400} → gptp_vaild at cycle 4, gptp_sw = 1, epoch/sec_offset = 0, nanosec_offset = 600, update_count = 1.
- Negative offset: same but t2_nano = 500001600 → epoch_offset = 16'hFFFF, sec_offset = 32'hFFFFFFFF, nanosec_offset = 999999400.
- Nanosecond carry: t1 = {0,7,999999500}, delay 1000, t2 = {0,8,0} → nanosec_offset = 500, sec_offset = 0.
- Step: t1 = {0,200,0}, delay 0, t2 = {0,100,0} → first request gptp_sw = 0, sec_r = 200, nanosec_r = 4; then gptp_sw = 1 with zero offsets; step_count = 1, update_count = 1. With C_STEP_ENABLE = 0 → single offset write, sec_offset = 100.
- Backpressure/reset: hold rtc_ready = 0 for 5 cycles → gptp_vaild and data stable, sample_ready = 0. Assert rtc_reset while waiting → next cycle gptp_vaild = 0, sample_ready = 1, counters = 0.
- Invalid input: t2_nano = 32'h3B9ACA00 → one-cycle err_invalid, no gptp_vaild, counters unchanged.
